// File: rtl/tdm_demux4_if.sv
// Bus bundle for the 4-channel TDM demultiplexer: inbound word stream, per-channel
// drain handshakes and status. The DUT uses the slave modport.
interface tdm_demux4_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_sof;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] out_data0;
  logic [WIDTH-1:0] out_data1;
  logic [WIDTH-1:0] out_data2;
  logic [WIDTH-1:0] out_data3;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [3:0]       overflow;
  logic             clr_ovf;
  logic             locked;
  logic             sync_err;
  logic [1:0]       slot;

  modport master (
    output in_valid, in_sof, in_data, out_ready, clr_ovf,
    input  out_data0, out_data1, out_data2, out_data3,
    input  out_valid, overflow, locked, sync_err, slot
  );

  modport slave (
    input  in_valid, in_sof, in_data, out_ready, clr_ovf,
    output out_data0, out_data1, out_data2, out_data3,
    output out_valid, overflow, locked, sync_err, slot
  );
endinterface

// File: rtl/tdm_demux4.sv
// Receive side of the 4:1 TDM word stream: finds frame alignment from the sof marker
// and routes each word into one of four handshaked holding registers.
module tdm_demux4 #(
  parameter int WIDTH = 16,
  parameter int NSLOT = 4
) (
  input  logic         clk,
  input  logic         rst,
  tdm_demux4_if.slave  tdm_io
);

  typedef enum logic {
    HUNT,
    LOCKED
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic             syncErr_q, syncErr_d;
  logic [WIDTH-1:0] data_q [NSLOT];
  logic [WIDTH-1:0] data_d [NSLOT];
  logic [NSLOT-1:0] valid_q, valid_d;
  logic [NSLOT-1:0] ovf_q, ovf_d;
  logic             route;
  logic [1:0]       beatSlot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= HUNT;
      slot_q    <= '0;
      syncErr_q <= 1'b0;
      valid_q   <= '0;
      ovf_q     <= '0;
      for (int n = 0; n < NSLOT; n++) begin
        data_q[n] <= '0;
      end
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      syncErr_q <= syncErr_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      for (int n = 0; n < NSLOT; n++) begin
        data_q[n] <= data_d[n];
      end
    end
  end

  // The sof that acquires lock is routed as slot 0 but is never a sync error.
  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    syncErr_d = 1'b0;
    route     = 1'b0;
    beatSlot  = slot_q;
    unique case (state_q)
      HUNT: begin
        if (tdm_io.in_valid && tdm_io.in_sof) begin
          state_d  = LOCKED;
          route    = 1'b1;
          beatSlot = '0;
        end
      end
      LOCKED: begin
        if (tdm_io.in_valid) begin
          route = 1'b1;
          if (tdm_io.in_sof) begin
            beatSlot  = '0;
            syncErr_d = (slot_q != '0);
          end
        end
      end
      default: state_d = HUNT;
    endcase
    if (route) begin
      slot_d = (beatSlot == 2'(NSLOT - 1)) ? '0 : beatSlot + 2'd1;
    end
  end

  // A word may land on a full register only if that register is drained on the same edge.
  always_comb begin
    logic hit;
    hit     = 1'b0;
    data_d  = data_q;
    valid_d = valid_q;
    ovf_d   = tdm_io.clr_ovf ? '0 : ovf_q;
    for (int n = 0; n < NSLOT; n++) begin
      hit = route && (beatSlot == 2'(n));
      if (hit && (!valid_q[n] || tdm_io.out_ready[n])) begin
        data_d[n]  = tdm_io.in_data;
        valid_d[n] = 1'b1;
      end else if (hit) begin
        ovf_d[n] = 1'b1;
      end else if (valid_q[n] && tdm_io.out_ready[n]) begin
        valid_d[n] = 1'b0;
      end
    end
  end

  always_comb begin
    tdm_io.locked    = (state_q == LOCKED);
    tdm_io.sync_err  = syncErr_q;
    tdm_io.slot      = slot_q;
    tdm_io.out_valid = valid_q;
    tdm_io.overflow  = ovf_q;
    tdm_io.out_data0 = data_q[0];
    tdm_io.out_data1 = data_q[1];
    tdm_io.out_data2 = data_q[2];
    tdm_io.out_data3 = data_q[3];
  end

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4: directed frames checked against a frame-level
// reference model every cycle, plus hand-computed spot checks.
module tb_tdm_demux4;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  tdm_demux4_if #(.WIDTH(16)) bus ();

  tdm_demux4 #(.WIDTH(16), .NSLOT(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .tdm_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: frame position and per-channel mailbox contents.
  int         mData [4];
  bit [3:0]   mValid;
  bit [3:0]   mOvf;
  bit         mLocked;
  int         mSlot;
  bit         mSync;

  always @(posedge clk or posedge rst) begin
    int dest;
    bit [3:0] dropped;
    if (rst) begin
      for (int n = 0; n < 4; n++) mData[n] = 0;
      mValid  = 4'b0;
      mOvf    = 4'b0;
      mLocked = 1'b0;
      mSlot   = 0;
      mSync   = 1'b0;
    end else begin
      dest    = -1;
      dropped = 4'b0;
      mSync   = 1'b0;
      if (bus.in_valid) begin
        if (!mLocked) begin
          if (bus.in_sof) begin
            mLocked = 1'b1;
            dest    = 0;
          end
        end else begin
          if (bus.in_sof && mSlot != 0) mSync = 1'b1;
          dest = bus.in_sof ? 0 : mSlot;
        end
        if (dest >= 0) mSlot = (dest + 1) % 4;
      end
      for (int n = 0; n < 4; n++) begin
        if (dest == n) begin
          if (mValid[n] && !bus.out_ready[n]) begin
            dropped[n] = 1'b1;
          end else begin
            mData[n]  = int'(bus.in_data);
            mValid[n] = 1'b1;
          end
        end else if (bus.out_ready[n]) begin
          mValid[n] = 1'b0;
        end
      end
      mOvf = (bus.clr_ovf ? 4'b0 : mOvf) | dropped;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("model out_valid", 32'(bus.out_valid), 32'(mValid));
      checkOutput("model overflow", 32'(bus.overflow), 32'(mOvf));
      checkOutput("model locked", 32'(bus.locked), 32'(mLocked));
      checkOutput("model sync_err", 32'(bus.sync_err), 32'(mSync));
      checkOutput("model slot", 32'(bus.slot), 32'(mSlot));
      checkOutput("model data0", 32'(bus.out_data0), 32'(mData[0]));
      checkOutput("model data1", 32'(bus.out_data1), 32'(mData[1]));
      checkOutput("model data2", 32'(bus.out_data2), 32'(mData[2]));
      checkOutput("model data3", 32'(bus.out_data3), 32'(mData[3]));
    end
  end

  task automatic applyStimulus(input bit v, input bit s, input logic [15:0] d,
                               input logic [3:0] rdy, input bit clr);
    bus.in_valid  = v;
    bus.in_sof    = s;
    bus.in_data   = d;
    bus.out_ready = rdy;
    bus.clr_ovf   = clr;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.clr_ovf  = 1'b0;
  endtask

  task automatic checkAllClear(input string tag);
    checkOutput({tag, " out_valid"}, 32'(bus.out_valid), 32'h0);
    checkOutput({tag, " overflow"}, 32'(bus.overflow), 32'h0);
    checkOutput({tag, " locked"}, 32'(bus.locked), 32'h0);
    checkOutput({tag, " sync_err"}, 32'(bus.sync_err), 32'h0);
    checkOutput({tag, " slot"}, 32'(bus.slot), 32'h0);
    checkOutput({tag, " data0"}, 32'(bus.out_data0), 32'h0);
    checkOutput({tag, " data3"}, 32'(bus.out_data3), 32'h0);
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sof    = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 4'b1111;
    bus.clr_ovf   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkAllClear("reset");
    rst = 1'b0;

    // Lock, then reset mid-stream and confirm HUNT discards non-sof beats
    applyStimulus(1, 1, 16'h0F00, 4'b1111, 0);
    checkOutput("prelock locked", 32'(bus.locked), 32'h1);
    #3;
    rst = 1'b1;
    #1;
    checkAllClear("midreset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1, 0, 16'hAAAA, 4'b1111, 0);
    applyStimulus(1, 0, 16'hBBBB, 4'b1111, 0);
    checkAllClear("hunt");

    // Lock and route one frame with all consumers ready
    applyStimulus(1, 1, 16'h1000, 4'b1111, 0);
    checkOutput("lock out_valid", 32'(bus.out_valid), 32'h1);
    checkOutput("lock data0", 32'(bus.out_data0), 32'h1000);
    checkOutput("lock locked", 32'(bus.locked), 32'h1);
    checkOutput("lock slot", 32'(bus.slot), 32'h1);
    applyStimulus(1, 0, 16'h1001, 4'b1111, 0);
    checkOutput("route1 out_valid", 32'(bus.out_valid), 32'h2);
    checkOutput("route1 data1", 32'(bus.out_data1), 32'h1001);
    applyStimulus(1, 0, 16'h1002, 4'b1111, 0);
    checkOutput("route2 out_valid", 32'(bus.out_valid), 32'h4);
    checkOutput("route2 data2", 32'(bus.out_data2), 32'h1002);
    applyStimulus(1, 0, 16'h1003, 4'b1111, 0);
    checkOutput("route3 out_valid", 32'(bus.out_valid), 32'h8);
    checkOutput("route3 data3", 32'(bus.out_data3), 32'h1003);
    checkOutput("route3 slot wrap", 32'(bus.slot), 32'h0);
    applyStimulus(0, 0, 16'h0, 4'b1111, 0);
    checkOutput("drained out_valid", 32'(bus.out_valid), 32'h0);

    // Channel 2 backpressured for two frames
    for (int i = 0; i < 4; i++) applyStimulus(1, i == 0, 16'h2000 + 16'(i), 4'b1011, 0);
    checkOutput("bp data2", 32'(bus.out_data2), 32'h2002);
    for (int i = 0; i < 4; i++) applyStimulus(1, i == 0, 16'h3000 + 16'(i), 4'b1011, 0);
    checkOutput("ovf data2 held", 32'(bus.out_data2), 32'h2002);
    checkOutput("ovf set", 32'(bus.overflow), 32'h4);
    checkOutput("ovf no sync_err", 32'(bus.sync_err), 32'h0);
    applyStimulus(0, 0, 16'h0, 4'b1011, 1);
    checkOutput("ovf cleared", 32'(bus.overflow), 32'h0);
    applyStimulus(1, 1, 16'h4000, 4'b1011, 0);
    applyStimulus(1, 0, 16'h4001, 4'b1011, 0);
    applyStimulus(1, 0, 16'h4002, 4'b1011, 1);
    checkOutput("ovf set wins", 32'(bus.overflow), 32'h4);
    applyStimulus(1, 0, 16'h4003, 4'b1011, 0);
    applyStimulus(0, 0, 16'h0, 4'b1111, 0);
    applyStimulus(0, 0, 16'h0, 4'b1111, 0);

    // Channel 1 read and written on the same edge
    for (int i = 0; i < 4; i++) applyStimulus(1, i == 0, 16'h0100 + 16'(i), 4'b1101, 0);
    checkOutput("rw pre data1", 32'(bus.out_data1), 32'h0101);
    applyStimulus(1, 1, 16'h0200, 4'b1101, 0);
    applyStimulus(1, 0, 16'h0201, 4'b1111, 0);
    checkOutput("rw data1", 32'(bus.out_data1), 32'h0201);
    checkOutput("rw valid1", 32'(bus.out_valid[1]), 32'h1);
    checkOutput("rw ovf1", 32'(bus.overflow[1]), 32'h0);
    applyStimulus(1, 0, 16'h0202, 4'b1111, 0);
    applyStimulus(1, 0, 16'h0203, 4'b1111, 0);
    applyStimulus(0, 0, 16'h0, 4'b1111, 0);

    // Early sof while the counter sits at slot 2
    applyStimulus(1, 1, 16'h6000, 4'b1111, 0);
    applyStimulus(1, 0, 16'h6001, 4'b1111, 0);
    checkOutput("resync pre slot", 32'(bus.slot), 32'h2);
    applyStimulus(1, 1, 16'h5555, 4'b1111, 0);
    checkOutput("resync sync_err", 32'(bus.sync_err), 32'h1);
    checkOutput("resync data0", 32'(bus.out_data0), 32'h5555);
    checkOutput("resync valid", 32'(bus.out_valid), 32'h1);
    checkOutput("resync slot", 32'(bus.slot), 32'h1);
    applyStimulus(1, 0, 16'h6666, 4'b1111, 0);
    checkOutput("resync pulse end", 32'(bus.sync_err), 32'h0);
    checkOutput("resync data1", 32'(bus.out_data1), 32'h6666);
    checkOutput("resync next valid", 32'(bus.out_valid), 32'h2);
    applyStimulus(0, 0, 16'h0, 4'b1111, 0);

    // Fill all four registers, then reset between edges
    for (int i = 0; i < 4; i++) applyStimulus(1, i == 0, 16'h7000 + 16'(i), 4'b0000, 0);
    checkOutput("full out_valid", 32'(bus.out_valid), 32'hF);
    #2;
    rst = 1'b1;
    #1;
    checkAllClear("asyncreset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1, 0, 16'h7777, 4'b1111, 0);
    checkAllClear("rehunt");
    applyStimulus(0, 0, 16'h0, 4'b1111, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Receive side of the 16-bit 4:1 time-division multiplexed word stream produced by the team's channel mux.
- Recovers slot alignment from a start-of-frame marker and routes each word to one of four per-channel holding registers.
- Each holding register is drained through an independent valid/ready handshake.
- The stream cannot be stalled, so words that would overwrite an unread register are dropped and flagged.

Parameters:
WIDTH, 16, data word width of input and all four output channels
NSLOT, 4, slots per frame; fixed at 4, slot index is 2 bits

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  input word present this cycle
in_sof  input  1  start of frame; qualified by in_valid; marks word as slot 0
in_data  input  WIDTH  input word
out_data0  output  WIDTH  channel 0 holding register
out_data1  output  WIDTH  channel 1 holding register
out_data2  output  WIDTH  channel 2 holding register
out_data3  output  WIDTH  channel 3 holding register
out_valid  output  4  bit n: channel n register holds unread word
out_ready  input  4  bit n: consumer of channel n accepts word
overflow  output  4  bit n: sticky, channel n dropped a word
clr_ovf  input  1  clears all overflow bits
locked  output  1  frame alignment acquired
sync_err  output  1  one-cycle pulse: in_sof arrived at unexpected slot
slot  output  2  slot index the next non-sof word will be assigned

Behaviour:
- Reset (async, rst=1): out_data0..3=0, out_valid=0, overflow=0, locked=0, sync_err=0, slot=0, state HUNT.
- Reset is honoured immediately and mid-frame; all buffered words are discarded.
- Beat = in_valid=1 on a rising edge. With in_valid=0, in_sof and in_data are ignored.
- State HUNT:
  - Beats with in_sof=0 are discarded; no routing, no overflow, slot stays 0.
  - A beat with in_sof=1 moves to LOCKED and routes that word as slot 0.
- State LOCKED:
  - Beat slot = 0 if in_sof=1, else the slot counter.
  - After the beat, the slot counter becomes (beat slot + 1) mod 4, wrapping 3->0.
  - LOCKED persists until reset.
- sync_err: asserted for exactly the cycle after a LOCKED beat with in_sof=1 while the slot counter is not 0.
  - The counter resynchronises to slot 0 on that same beat.
  - The sof that causes the HUNT->LOCKED transition never raises sync_err.
- locked equals (state == LOCKED), registered.
- Routing latency: a word accepted on edge k appears on out_dataN with out_valid[N]=1 after edge k (1-cycle latency).
- Channel N register update per edge:
  - Write only: load data, set valid.
  - Read only (out_valid[N]&out_ready[N]): clear valid; data holds last value.
  - Write and read same edge: load new data, valid stays 1 (full throughput, no bubble).
  - Write while valid=1 and out_ready[N]=0: new word dropped, register unchanged, overflow[N] set.
  - out_dataN changes only on load; stable while out_valid[N]=1 and not read.
- out_ready[N] with out_valid[N]=0 has no effect.
- overflow: sticky until clr_ovf=1. Set and clear on the same edge -> set wins (bit stays 1).
- Only the routed channel is affected by a beat; other channels drain independently in the same cycle.

Test Plan:
- Reset/HUNT: assert rst mid-stream, release; send beats 0xAAAA, 0xBBBB with in_sof=0 -> out_valid=0000, locked=0, overflow=0000, slot=0.
- Lock and route: beats 0x1000(sof), 0x1001, 0x1002, 0x1003 with out_ready=1111 -> one cycle after each beat out_valid bit 0,1,2,3 pulses with data 0x1000..0x1003; locked=1 after first beat; slot wraps to 0.
- Backpressure/overflow: out_ready[2]=0 for two frames (slot2 words 0x2002 then 0x3002) -> out_data2 holds 0x2002, overflow=0100; pulse clr_ovf -> overflow=0000; clr_ovf coincident with a new drop -> overflow[2] stays 1.
- Simultaneous read/write: channel 1 valid with 0x0101, out_ready[1]=1 on the same edge slot-1 word 0x0201 arrives -> out_data1=0x0201, out_valid[1] stays 1, overflow[1]=0.
- Resync: LOCKED, slot counter=2, beat 0x5555 with in_sof=1 -> sync_err high exactly one cycle, word routed to channel 0, next beat routed to channel 1.
- Async reset mid-operation: rst asserted between edges with out_valid=1111 -> all outputs 0 immediately, before the next clock edge; HUNT re-entered.
